// File: rtl/step_clock_controller_pkg.sv
// Shared board-level constants for the step clock controller and the HEX display logic.
// Derived defaults assume the 50 MHz board clock.
package step_clock_controller_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int RUN_HZ      = 1;

  localparam int DEF_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEF_RUN_PERIOD      = CLK_HZ / RUN_HZ;
  localparam int DEF_COUNT_WIDTH     = 16;

  // Bits needed for a counter that runs 0..max_value-1 (never narrower than 1).
  function automatic int count_bits(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer plus stable-time filter for an active-low pushbutton.
// pressed flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module debounce_filter
  import step_clock_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_n,
  output logic pressed
);

  localparam int CW = count_bits(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_pressed;
  logic [CW-1:0] r_count;
  logic          w_differs;

  assign w_differs = (~r_sync2) != r_pressed;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_pressed <= 1'b0;
      r_count   <= '0;
    end else begin
      r_sync1 <= raw_n;
      r_sync2 <= r_sync1;
      // Any cycle of agreement restarts the stable-time count.
      if (!w_differs) begin
        r_count <= '0;
      end else if (r_count == LAST) begin
        r_pressed <= ~r_pressed;
        r_count   <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign pressed = r_pressed;

endmodule

// File: rtl/step_clock_controller.sv
// Single-domain clock-enable generator: debounced manual single-step or divided free-run,
// plus the strobe counter and the register reset held while the count is zero.
module step_clock_controller
  import step_clock_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RUN_PERIOD      = DEF_RUN_PERIOD,
  parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   step_button_n,
  input  logic                   run_mode,
  output logic                   step_en,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic                   cpu_reset,
  output logic                   run_active,
  output logic                   button_pressed
);

  localparam int DW = count_bits(RUN_PERIOD);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_PERIOD - 1);

  logic                   w_pressed;
  logic                   r_mode_sync1;
  logic                   r_mode_sync2;
  logic                   r_pressed_prev;
  logic                   r_manual_strobe;
  logic [DW-1:0]          r_divider;
  logic [COUNT_WIDTH-1:0] r_cycle_count;
  logic                   r_cpu_reset;
  logic                   w_run_strobe;
  logic                   w_step_en;
  logic [COUNT_WIDTH-1:0] w_next_count;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .raw_n   (step_button_n),
    .pressed (w_pressed)
  );

  // The divider sits at 0 outside run mode, so the two strobe sources never overlap.
  assign w_run_strobe = r_mode_sync2 && (r_divider == DIV_LAST);
  assign w_step_en    = w_run_strobe | r_manual_strobe;
  assign w_next_count = r_cycle_count + COUNT_WIDTH'(w_step_en);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mode_sync1    <= 1'b0;
      r_mode_sync2    <= 1'b0;
      r_pressed_prev  <= 1'b0;
      r_manual_strobe <= 1'b0;
      r_divider       <= '0;
      r_cycle_count   <= '0;
      r_cpu_reset     <= 1'b1;
    end else begin
      r_mode_sync1    <= run_mode;
      r_mode_sync2    <= r_mode_sync1;
      // The edge is consumed even in run mode, so a press during run is never replayed.
      r_pressed_prev  <= w_pressed;
      r_manual_strobe <= w_pressed & ~r_pressed_prev & ~r_mode_sync2;
      if (!r_mode_sync2 || r_divider == DIV_LAST) begin
        r_divider <= '0;
      end else begin
        r_divider <= r_divider + DW'(1);
      end
      r_cycle_count <= w_next_count;
      r_cpu_reset   <= (w_next_count == '0);
    end
  end

  assign step_en        = w_step_en;
  assign cycle_count    = r_cycle_count;
  assign cpu_reset      = r_cpu_reset;
  assign run_active     = r_mode_sync2;
  assign button_pressed = w_pressed;

endmodule

// File: tb/tb_step_clock_controller.sv
// Bench for step_clock_controller: segment table, hand-written timing sequences and
// randomized button/mode activity, all checked against a cycle-level reference model.
module tb_step_clock_controller;

  localparam int DC = 4;
  localparam int RP = 8;
  localparam int CW = 4;

  logic          clock;
  logic          reset_n;
  logic          step_button_n;
  logic          run_mode;
  logic          step_en;
  logic [CW-1:0] cycle_count;
  logic          cpu_reset;
  logic          run_active;
  logic          button_pressed;

  step_clock_controller #(
    .DEBOUNCE_CYCLES(DC),
    .RUN_PERIOD     (RP),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .step_button_n  (step_button_n),
    .run_mode       (run_mode),
    .step_en        (step_en),
    .cycle_count    (cycle_count),
    .cpu_reset      (cpu_reset),
    .run_active     (run_active),
    .button_pressed (button_pressed)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_errors;
  int seg_strobes;

  // Reference model: raw input histories, a window of synchronized samples,
  // and the run length of run_active.
  bit step_q[$];
  bit mode_q[$];
  bit psync_q[$];
  bit m_db;
  bit m_rose;
  bit m_run_active;
  bit m_step_en;
  bit m_cpu_reset;
  int m_run_len;
  int m_count;

  typedef struct {
    logic step_n;
    logic mode;
    int   cycles;
    int   exp_strobes;
    int   exp_count;
    logic exp_pressed;
    logic exp_run;
  } seg_t;

  seg_t segs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    step_q = '{1'b1, 1'b1, 1'b1};
    mode_q = '{1'b0, 1'b0};
    psync_q.delete();
    for (int i = 0; i < DC; i++) psync_q.push_back(1'b0);
    m_db         = 1'b0;
    m_rose       = 1'b0;
    m_run_active = 1'b0;
    m_step_en    = 1'b0;
    m_cpu_reset  = 1'b1;
    m_run_len    = 0;
    m_count      = 0;
  endtask

  // One active clock edge: outputs for the following cycle.
  task automatic model_edge();
    bit prev_step_en;
    bit prev_run;
    bit prev_rose;
    bit all_diff;
    prev_step_en = m_step_en;
    prev_run     = m_run_active;
    prev_rose    = m_rose;
    step_q.push_back(step_button_n);
    mode_q.push_back(run_mode);
    // The button value seen now was sampled two edges ago; stored as 1 = pressed.
    psync_q.push_back(!step_q[step_q.size() - 3]);
    if (psync_q.size() > DC) void'(psync_q.pop_front());
    all_diff = 1'b1;
    foreach (psync_q[i]) if (psync_q[i] == m_db) all_diff = 1'b0;
    m_rose = 1'b0;
    if (all_diff) begin
      m_db   = !m_db;
      m_rose = m_db;
    end
    m_run_active = mode_q[mode_q.size() - 2];
    m_run_len    = m_run_active ? m_run_len + 1 : 0;
    m_step_en    = (prev_rose && !prev_run) ||
                   (m_run_active && (m_run_len % RP == 0));
    if (prev_step_en) m_count = (m_count + 1) % (1 << CW);
    m_cpu_reset = (m_count == 0);
    while (step_q.size() > 4) void'(step_q.pop_front());
    while (mode_q.size() > 4) void'(mode_q.pop_front());
  endtask

  task automatic compare_model();
    check("step_en", step_en, m_step_en);
    check("cycle_count", cycle_count, m_count);
    check("cpu_reset", cpu_reset, m_cpu_reset);
    check("run_active", run_active, m_run_active);
    check("button_pressed", button_pressed, m_db);
  endtask

  // Always entered and left at a falling edge.
  task automatic tick();
    @(posedge clock);
    if (reset_n) model_edge();
    @(negedge clock);
    compare_model();
    if (step_en) seg_strobes++;
  endtask

  task automatic apply_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    repeat (n) tick();
    check("rst_step_en", step_en, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_run_active", run_active, 0);
    check("rst_button_pressed", button_pressed, 0);
    reset_n = 1'b1;
  endtask

  task automatic press_latency(input string name);
    step_button_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check(name, step_en, (i == 7) ? 1 : 0);
    end
  endtask

  task automatic press_release(input int n);
    for (int p = 0; p < n; p++) begin
      step_button_n = 1'b0;
      repeat (10) tick();
      step_button_n = 1'b1;
      repeat (10) tick();
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    seg_strobes   = 0;
    reset_n       = 1'b0;
    step_button_n = 1'b1;
    run_mode      = 1'b0;
    model_reset();

    // step_n, mode, cycles, strobes, final count, pressed, run_active
    segs[0] = '{1'b1, 1'b0,   5,  0, 13 - 13, 1'b0, 1'b0};
    segs[1] = '{1'b0, 1'b0,  20,  1,  1, 1'b1, 1'b0};
    segs[2] = '{1'b1, 1'b0,  20,  0,  1, 1'b0, 1'b0};
    segs[3] = '{1'b1, 1'b1, 100, 12, 13, 1'b0, 1'b1};
    segs[4] = '{1'b0, 1'b1,  22,  3,  0, 1'b1, 1'b1};
    segs[5] = '{1'b0, 1'b0,  20,  0,  0, 1'b1, 1'b0};
    segs[6] = '{1'b1, 1'b0,  20,  0,  0, 1'b0, 1'b0};
    segs[7] = '{1'b0, 1'b0,  20,  1,  1, 1'b1, 1'b0};

    @(negedge clock);
    apply_reset(3);

    for (int s = 0; s < 8; s++) begin
      step_button_n = segs[s].step_n;
      run_mode      = segs[s].mode;
      seg_strobes   = 0;
      repeat (segs[s].cycles) tick();
      check($sformatf("seg%0d_strobes", s), seg_strobes, segs[s].exp_strobes);
      check($sformatf("seg%0d_count", s), cycle_count, segs[s].exp_count);
      check($sformatf("seg%0d_cpu_reset", s), cpu_reset, (segs[s].exp_count == 0) ? 1 : 0);
      check($sformatf("seg%0d_pressed", s), button_pressed, segs[s].exp_pressed);
      check($sformatf("seg%0d_run", s), run_active, segs[s].exp_run);
    end

    // Clean press latency from an idle released state.
    step_button_n = 1'b1;
    repeat (10) tick();
    press_latency("clean_latency");
    step_button_n = 1'b1;
    seg_strobes = 0;
    repeat (10) tick();
    check("release_strobes", seg_strobes, 0);

    // Bounce: toggles every 2 cycles, then a stable press.
    seg_strobes = 0;
    for (int k = 0; k < 12; k++) begin
      step_button_n = logic'((k / 2) % 2);
      tick();
    end
    check("bounce_strobes", seg_strobes, 0);
    press_latency("bounce_latency");
    step_button_n = 1'b1;
    repeat (10) tick();

    // Reset while running, then the first run strobe releases cpu_reset.
    run_mode = 1'b1;
    repeat (20) tick();
    apply_reset(3);
    repeat (9) tick();
    check("run_first_strobe", step_en, 1);
    check("run_pre_count", cycle_count, 0);
    check("run_pre_cpu_reset", cpu_reset, 1);
    tick();
    check("run_post_count", cycle_count, 1);
    check("run_post_cpu_reset", cpu_reset, 0);
    run_mode = 1'b0;
    repeat (5) tick();

    // Wrap after 16 manual presses from reset.
    apply_reset(2);
    press_release(1);
    check("wrap_press1_count", cycle_count, 1);
    press_release(15);
    check("wrap_press16_count", cycle_count, 0);
    check("wrap_press16_cpu_reset", cpu_reset, 1);
    press_release(1);
    check("wrap_press17_count", cycle_count, 1);
    check("wrap_press17_cpu_reset", cpu_reset, 0);

    // Randomized activity against the model.
    for (int r = 0; r < 120; r++) begin
      if ($urandom_range(0, 39) == 0) begin
        apply_reset($urandom_range(1, 3));
      end
      step_button_n = logic'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) run_mode = ~run_mode;
      repeat ($urandom_range(1, 12)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
